wb_pattern_master: RTL and testbench
====================================

WB_PATTERN_MASTER -- requirements
Module: wb_pattern_master

Interface
REQ-001 SHALL have parameter dw, default 32, Wishbone data width in bits (legal values 32 only).
REQ-002 SHALL have parameter APP_AW, default 26, Wishbone byte-address width.
REQ-003 SHALL have parameter BL, default 8, beats per burst (power of two, 1..16).
REQ-004 SHALL have port wb_clk_i  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port wb_resetn  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports start in 1 (run request pulse); sdr_init_done in 1 (controller init complete).
REQ-007 SHALL have ports base_addr in APP_AW (first byte address, dw/8-aligned); num_bursts in 16 (bursts per phase); seed in 32 (pattern seed).
REQ-008 SHALL have Wishbone master ports wb_cyc_o, wb_stb_o, wb_we_o out 1; wb_addr_o out APP_AW; wb_dat_o out dw; wb_sel_o out dw/8; wb_cti_o out 3; wb_ack_i in 1; wb_dat_i in dw.
REQ-009 SHALL have status ports busy out 1; done out 1 (one-cycle pulse); pass out 1; err_count out 16; first_err_addr out APP_AW.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT_INIT, WR_BURST, WR_GAP, RD_BURST, RD_GAP, FINISH.
REQ-011 SHALL move IDLE->WAIT_INIT on start=1; start SHALL be ignored in all other states.
REQ-012 SHALL move WAIT_INIT->WR_BURST on the first cycle sdr_init_done=1, or to FINISH if num_bursts=0.
REQ-013 SHALL, in WR_BURST/RD_BURST, assert cyc and stb, hold addr/dat/we/cti stable until wb_ack_i=1, and advance one beat per acked cycle.
REQ-014 SHALL drive wb_cti_o=3'b010 on all beats except the last of each burst, which SHALL use 3'b111; wb_sel_o SHALL be all ones.
REQ-015 SHALL increment wb_addr_o by dw/8 per beat, wrapping modulo 2^APP_AW.
REQ-016 SHALL deassert cyc/stb for exactly one cycle (WR_GAP/RD_GAP) between bursts.
REQ-017 SHALL, after num_bursts write bursts, restart address at base_addr and pattern generator, then enter RD_BURST with wb_we_o=0.
REQ-018 SHALL compare wb_dat_i with expected pattern on each acked read beat; on mismatch increment err_count (saturating at 16'hFFFF) and latch first_err_addr on the first mismatch only.
REQ-019 SHALL after the last read burst enter FINISH, pulse done for one cycle, set pass=(err_count==0), then return to IDLE.
REQ-020 SHALL hold busy=1 in every state except IDLE; err_count, first_err_addr, pass SHALL clear on entry to WAIT_INIT.
REQ-021 SHALL ignore wb_ack_i whenever wb_stb_o=0.
REQ-022 SHALL, without the macro of REQ-026, use expected data = {address zero-extended to dw} XOR seed.

Reset
REQ-023 SHALL, on wb_resetn=0, asynchronously force state IDLE and all outputs to 0, including mid-burst (cyc/stb drop immediately).
REQ-024 SHALL resume only via a new start after reset release.
REQ-025 SHALL reset the beat counter, burst counter, and LFSR (to 0; loaded from seed on entry to WAIT_INIT).

Configuration
REQ-026 SHALL, with WB_PATTERN_LFSR_EN defined, generate data from a 32-bit Galois LFSR (taps 32,22,2,1), loaded from seed (seed=0 replaced by 32'h1), stepping once per acked beat, reloaded before read phase; without it, REQ-022 applies and no LFSR logic is instantiated.

Structure
REQ-027 SHALL place the FSM state enum, CTI constants (CTI_INCR=3'b010, CTI_EOB=3'b111), and LFSR tap constant in package wb_pattern_pkg.
REQ-028 SHALL implement pattern generation in one sub-module wb_pattern_gen (address-XOR or LFSR, load/step inputs).

Verification
REQ-029 base_addr=0, num_bursts=2, BL=8, seed=0, zero-wait-state slave -> 16 writes addr 0x00..0x3C, data equal to addr, cti 010x7/111 per burst, one idle cycle between bursts, then 16 matching reads, done pulse, pass=1, err_count=0.
REQ-030 Slave corrupts read beat at address 0x14 (bit 0 flipped) -> err_count=1, first_err_addr=0x14, pass=0.
REQ-031 num_bursts=0, sdr_init_done=1 -> no cyc asserted, done pulse within 3 cycles of start, pass=1.
REQ-032 base_addr=2^26-16, num_bursts=1, BL=8 -> addresses wrap 0x3FFFFF0, ..., 0x3FFFFFC, 0x0, ..., 0xC; pass=1.
REQ-033 Slave inserts 3 wait states per beat; wb_resetn pulsed low during write beat 5 -> cyc/stb/busy low same cycle, state IDLE, new start reruns to pass=1.
REQ-034 With WB_PATTERN_LFSR_EN, seed=32'h1 -> first write data 32'h1, read phase repeats identical sequence, pass=1; start held high during run -> no restart.

Source files
------------

// File: rtl/wb_pattern_pkg.sv
// Shared definitions for the Wishbone pattern master: FSM states, burst
// cycle-type codes and the LFSR feedback mask.
package wb_pattern_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_INIT,
      WR_BURST,
      WR_GAP,
      RD_BURST,
      RD_GAP,
      FINISH
   } state_e;

   localparam logic [2:0] CTI_INCR = 3'b010;
   localparam logic [2:0] CTI_EOB  = 3'b111;

   // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   function automatic logic [31:0] lfsrNext(input logic [31:0] cur);
      return {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_TAPS : 32'h0);
   endfunction

endpackage

// File: rtl/wb_pattern_gen.sv
// Test-pattern generator for the Wishbone pattern master.
// Default build: data is the beat address zero-extended and XORed with the seed.
// With WB_PATTERN_LFSR_EN defined: data comes from a 32-bit Galois LFSR that is
// loaded from the seed (a zero seed becomes 1) and steps once per accepted beat.
module wb_pattern_gen #(
   parameter int dw     = 32,
   parameter int APP_AW = 26
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [31:0]       seed_i,
   input  logic [APP_AW-1:0] addr_i,
   output logic [dw-1:0]     data_o
);
   import wb_pattern_pkg::*;

`ifdef WB_PATTERN_LFSR_EN
   logic [31:0] lfsr_q;
   logic        unused_addr;

   // Load wins over step so a reload before the read phase restarts the sequence cleanly
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q <= 32'h0;
      end else if (load_i) begin
         lfsr_q <= (seed_i == 32'h0) ? 32'h1 : seed_i;
      end else if (step_i) begin
         lfsr_q <= lfsrNext(lfsr_q);
      end
   end

   assign data_o      = dw'(lfsr_q);
   assign unused_addr = ^addr_i;
`else
   logic unused_genInputs;

   assign data_o           = dw'(addr_i) ^ dw'(seed_i);
   assign unused_genInputs = ^{clk_i, rst_ni, load_i, step_i};
`endif

endmodule

// File: rtl/wb_pattern_master.sv
// Wishbone burst pattern master: writes num_bursts incrementing bursts of a
// generated pattern starting at base_addr, then reads them back and counts
// mismatches. Optional LFSR data source selected by WB_PATTERN_LFSR_EN.
module wb_pattern_master #(
   parameter int dw     = 32,
   parameter int APP_AW = 26,
   parameter int BL     = 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_resetn,
   input  logic              start,
   input  logic              sdr_init_done,
   input  logic [APP_AW-1:0] base_addr,
   input  logic [15:0]       num_bursts,
   input  logic [31:0]       seed,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [APP_AW-1:0] wb_addr_o,
   output logic [dw-1:0]     wb_dat_o,
   output logic [dw/8-1:0]   wb_sel_o,
   output logic [2:0]        wb_cti_o,
   input  logic              wb_ack_i,
   input  logic [dw-1:0]     wb_dat_i,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_count,
   output logic [APP_AW-1:0] first_err_addr
);
   import wb_pattern_pkg::*;

   state_e            state_q, state_d;
   logic [APP_AW-1:0] addr_q, addr_d;
   logic [4:0]        beatCnt_q, beatCnt_d;
   logic [15:0]       burstCnt_q, burstCnt_d;
   logic [APP_AW-1:0] base_q, base_d;
   logic [15:0]       numBursts_q, numBursts_d;
   logic [31:0]       seed_q, seed_d;
   logic [15:0]       errCount_q, errCount_d;
   logic [APP_AW-1:0] firstErr_q, firstErr_d;
   logic              pass_q, pass_d;

   logic              inBurst, lastBeat, ackBeat;
   logic              genLoad, genStep;
   logic [31:0]       genSeed;
   logic [dw-1:0]     pattern;

   assign inBurst  = (state_q == WR_BURST) || (state_q == RD_BURST);
   assign lastBeat = (beatCnt_q == 5'(BL - 1));
   assign ackBeat  = inBurst && wb_ack_i;
   assign genStep  = ackBeat;
   assign genSeed  = (state_q == IDLE) ? seed : seed_q;

   wb_pattern_gen #(
      .dw    (dw),
      .APP_AW(APP_AW)
   ) u_gen (
      .clk_i (wb_clk_i),
      .rst_ni(wb_resetn),
      .load_i(genLoad),
      .step_i(genStep),
      .seed_i(genSeed),
      .addr_i(addr_q),
      .data_o(pattern)
   );

   // State and datapath registers; reset drops the bus immediately, even mid-burst
   always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
      if (!wb_resetn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         beatCnt_q   <= '0;
         burstCnt_q  <= '0;
         base_q      <= '0;
         numBursts_q <= '0;
         seed_q      <= '0;
         errCount_q  <= '0;
         firstErr_q  <= '0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         beatCnt_q   <= beatCnt_d;
         burstCnt_q  <= burstCnt_d;
         base_q      <= base_d;
         numBursts_q <= numBursts_d;
         seed_q      <= seed_d;
         errCount_q  <= errCount_d;
         firstErr_q  <= firstErr_d;
         pass_q      <= pass_d;
      end
   end

   // Next-state logic: write phase, one-cycle gaps, read-back phase with checking
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      beatCnt_d   = beatCnt_q;
      burstCnt_d  = burstCnt_q;
      base_d      = base_q;
      numBursts_d = numBursts_q;
      seed_d      = seed_q;
      errCount_d  = errCount_q;
      firstErr_d  = firstErr_q;
      pass_d      = pass_q;
      genLoad     = 1'b0;

      if (ackBeat) begin
         addr_d    = addr_q + APP_AW'(dw / 8);
         beatCnt_d = lastBeat ? 5'd0 : beatCnt_q + 5'd1;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = WAIT_INIT;
               base_d      = base_addr;
               numBursts_d = num_bursts;
               seed_d      = seed;
               errCount_d  = '0;
               firstErr_d  = '0;
               pass_d      = 1'b0;
               genLoad     = 1'b1;
            end
         end
         WAIT_INIT: begin
            if (sdr_init_done) begin
               addr_d     = base_q;
               beatCnt_d  = '0;
               burstCnt_d = '0;
               if (numBursts_q == 16'd0) begin
                  state_d = FINISH;
                  pass_d  = 1'b1;
               end else begin
                  state_d = WR_BURST;
               end
            end
         end
         WR_BURST: begin
            if (ackBeat && lastBeat) begin
               burstCnt_d = burstCnt_q + 16'd1;
               state_d    = WR_GAP;
            end
         end
         WR_GAP: begin
            if (burstCnt_q == numBursts_q) begin
               state_d    = RD_BURST;
               burstCnt_d = '0;
               addr_d     = base_q;
               genLoad    = 1'b1;
            end else begin
               state_d = WR_BURST;
            end
         end
         RD_BURST: begin
            if (ackBeat && (wb_dat_i != pattern)) begin
               if (errCount_q != 16'hFFFF) begin
                  errCount_d = errCount_q + 16'd1;
               end
               if (errCount_q == 16'd0) begin
                  firstErr_d = addr_q;
               end
            end
            if (ackBeat && lastBeat) begin
               burstCnt_d = burstCnt_q + 16'd1;
               if ((burstCnt_q + 16'd1) == numBursts_q) begin
                  state_d = FINISH;
                  pass_d  = (errCount_d == 16'd0);
               end else begin
                  state_d = RD_GAP;
               end
            end
         end
         RD_GAP: begin
            state_d = RD_BURST;
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign wb_cyc_o       = inBurst;
   assign wb_stb_o       = inBurst;
   assign wb_we_o        = (state_q == WR_BURST);
   assign wb_addr_o      = addr_q;
   assign wb_dat_o       = wb_we_o ? pattern : '0;
   assign wb_sel_o       = inBurst ? '1 : '0;
   assign wb_cti_o       = inBurst ? (lastBeat ? CTI_EOB : CTI_INCR) : 3'b000;
   assign busy           = (state_q != IDLE);
   assign done           = (state_q == FINISH);
   assign pass           = pass_q;
   assign err_count      = errCount_q;
   assign first_err_addr = firstErr_q;

endmodule

// File: tb/tb_wb_pattern_master.sv
// Self-checking bench for wb_pattern_master: a Wishbone slave with a small
// memory, optional wait states and single-address read corruption, plus a bus
// monitor. Expected traffic is rebuilt from the run parameters.
module tb_wb_pattern_master;

   localparam int DW = 32;
   localparam int AW = 26;
   localparam int BLEN = 8;

   logic          clock = 1'b0;
   logic          wbResetn;
   logic          start, sdrInitDone;
   logic [AW-1:0] baseAddr;
   logic [15:0]   numBursts;
   logic [31:0]   seed;
   logic          cyc, stb, we, ack;
   logic [AW-1:0] addr;
   logic [DW-1:0] datOut, datIn;
   logic [3:0]    sel;
   logic [2:0]    cti;
   logic          busy, done, pass;
   logic [15:0]   errCount;
   logic [AW-1:0] firstErrAddr;

   int            checkCount = 0;
   int            passCount = 0;

   int            waitStates = 0;
   logic          corruptEn = 1'b0;
   logic [AW-1:0] corruptAddr = '0;
   int            waitCnt = 0;
   int            cycNum = 0;
   logic [31:0]   mem [64];

   logic [63:0]   logQ [$];
   int            cycQ [$];
   int            logBase, cycBase, startCyc, doneCyc;
   logic          gotDone, donePass, doneAfter, busyAfter;
   logic [15:0]   doneErr;
   logic [AW-1:0] doneFirst;

   wb_pattern_master #(.dw(DW), .APP_AW(AW), .BL(BLEN)) dut (
      .wb_clk_i      (clock),
      .wb_resetn     (wbResetn),
      .start         (start),
      .sdr_init_done (sdrInitDone),
      .base_addr     (baseAddr),
      .num_bursts    (numBursts),
      .seed          (seed),
      .wb_cyc_o      (cyc),
      .wb_stb_o      (stb),
      .wb_we_o       (we),
      .wb_addr_o     (addr),
      .wb_dat_o      (datOut),
      .wb_sel_o      (sel),
      .wb_cti_o      (cti),
      .wb_ack_i      (ack),
      .wb_dat_i      (datIn),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_count     (errCount),
      .first_err_addr(firstErrAddr)
   );

   // Free-running clock
   always #5 clock = ~clock;

   // Slave response: ack after the configured number of wait states, read data from memory
   always_comb begin
      ack   = cyc && stb && (waitCnt == waitStates);
      datIn = mem[addr[7:2]];
      if (corruptEn && !we && (addr == corruptAddr)) begin
         datIn = datIn ^ 32'h1;
      end
   end

   // Slave wait-state counter, memory writes and bus monitor
   always @(posedge clock) begin
      cycNum <= cycNum + 1;
      waitCnt <= (cyc && stb && !ack) ? waitCnt + 1 : 0;
      if (wbResetn && cyc) begin
         cycQ.push_back(cycNum);
      end
      if (wbResetn && cyc && stb && ack) begin
         logQ.push_back({2'b00, we, cti, addr, (we ? datOut : 32'h0)});
         if (we) begin
            mem[addr[7:2]] <= datOut;
         end
      end
   end

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         passCount++;
      end
   endtask

   // Reference data for beat j of a phase at byte address a
   function automatic logic [31:0] modelData(input int j, input logic [AW-1:0] a, input logic [31:0] s);
`ifdef WB_PATTERN_LFSR_EN
      logic [31:0] x;
      x = (s == 32'h0) ? 32'h1 : s;
      for (int i = 0; i < j; i++) begin
         x = {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
      end
      return x;
`else
      return {6'b0, a} ^ s;
`endif
   endfunction

   // Start one run and wait (bounded) for the done pulse
   task automatic applyStimulus(input logic [AW-1:0] b, input logic [15:0] n, input logic [31:0] s,
                                input int ws, input logic cEn, input logic [AW-1:0] cAddr, input logic hold);
      @(negedge clock);
      baseAddr    = b;
      numBursts   = n;
      seed        = s;
      waitStates  = ws;
      corruptEn   = cEn;
      corruptAddr = cAddr;
      logBase     = logQ.size();
      cycBase     = cycQ.size();
      startCyc    = cycNum;
      start       = 1'b1;
      gotDone     = 1'b0;
      if (!hold) begin
         @(negedge clock);
         start = 1'b0;
         if (done) gotDone = 1'b1;
      end
      for (int c = 0; c < 3000 && !gotDone; c++) begin
         @(negedge clock);
         if (done) gotDone = 1'b1;
      end
      start     = 1'b0;
      doneCyc   = cycNum;
      donePass  = pass;
      doneErr   = errCount;
      doneFirst = firstErrAddr;
      @(negedge clock);
      doneAfter = done;
      busyAfter = busy;
      checkOutput("doneSeen", 64'(gotDone), 64'd1);
   endtask

   // Compare the finished run against the expected bus trace and status
   task automatic checkRun(input string name, input logic [AW-1:0] b, input logic [15:0] n, input logic [31:0] s,
                           input int ws, input logic expPass, input logic [15:0] expErr, input logic [AW-1:0] expFirst);
      int total, perPhase, nLog, nCyc;
      logic [AW-1:0] a;
      logic          isWr;
      int            j;
      logic [2:0]    c;
      checkOutput({name, ".pass"}, 64'(donePass), 64'(expPass));
      checkOutput({name, ".errCount"}, 64'(doneErr), 64'(expErr));
      checkOutput({name, ".firstErr"}, 64'(doneFirst), 64'(expFirst));
      checkOutput({name, ".donePulse"}, 64'(doneAfter), 64'd0);
      checkOutput({name, ".idleAfter"}, 64'(busyAfter), 64'd0);
      perPhase = BLEN * int'(n);
      total    = 2 * perPhase;
      nLog     = logQ.size() - logBase;
      nCyc     = cycQ.size() - cycBase;
      checkOutput({name, ".beats"}, 64'(nLog), 64'(total));
      checkOutput({name, ".cycCycles"}, 64'(nCyc), 64'(total * (ws + 1)));
      if (n != 16'd0 && nCyc > 0) begin
         checkOutput({name, ".spanWithGaps"}, 64'(cycQ[cycQ.size() - 1] - cycQ[cycBase] + 1),
                     64'(total * (ws + 1) + 2 * int'(n) - 1));
      end
      for (int k = 0; k < total && k < nLog; k++) begin
         isWr = (k < perPhase);
         j    = isWr ? k : k - perPhase;
         a    = b + AW'(4 * j);
         c    = ((j % BLEN) == BLEN - 1) ? 3'b111 : 3'b010;
         checkOutput($sformatf("%s.beat%0d", name, k), logQ[logBase + k],
                     {2'b00, isWr, c, a, (isWr ? modelData(j, a, s) : 32'h0)});
      end
   endtask

   initial begin
      wbResetn    = 1'b0;
      start       = 1'b0;
      sdrInitDone = 1'b1;
      baseAddr    = '0;
      numBursts   = '0;
      seed        = '0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      repeat (3) @(negedge clock);
      checkOutput("rst.cyc", 64'({cyc, stb, we}), 64'd0);
      checkOutput("rst.busy", 64'({busy, done, pass}), 64'd0);
      checkOutput("rst.addr", 64'(addr), 64'd0);
      checkOutput("rst.errCount", 64'(errCount), 64'd0);
      wbResetn = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("idle.busy", 64'(busy), 64'd0);

      $display("[TB] basic write/read run");
      applyStimulus(26'h0, 16'd2, 32'h0, 0, 1'b0, 26'h0, 1'b0);
      checkRun("basic", 26'h0, 16'd2, 32'h0, 0, 1'b1, 16'd0, 26'h0);

      $display("[TB] corrupted read at 0x14");
      applyStimulus(26'h0, 16'd2, 32'h0, 0, 1'b1, 26'h14, 1'b0);
      checkRun("corrupt", 26'h0, 16'd2, 32'h0, 0, 1'b0, 16'd1, 26'h14);

      $display("[TB] zero bursts");
      applyStimulus(26'h0, 16'd0, 32'h0, 0, 1'b0, 26'h0, 1'b0);
      checkOutput("zero.latency", 64'(doneCyc - startCyc <= 3), 64'd1);
      checkRun("zero", 26'h0, 16'd0, 32'h0, 0, 1'b1, 16'd0, 26'h0);

      $display("[TB] address wrap with start held high");
      applyStimulus(26'h3FF_FFF0, 16'd1, 32'h0, 0, 1'b0, 26'h0, 1'b1);
      checkRun("wrap", 26'h3FF_FFF0, 16'd1, 32'h0, 0, 1'b1, 16'd0, 26'h0);

      $display("[TB] reset during write beat 5 with wait states");
      @(negedge clock);
      baseAddr   = 26'h100;
      numBursts  = 16'd2;
      seed       = 32'hA5A5_0000;
      waitStates = 3;
      corruptEn  = 1'b0;
      logBase    = logQ.size();
      start      = 1'b1;
      @(negedge clock);
      start = 1'b0;
      gotDone = 1'b0;
      for (int c = 0; c < 400 && (logQ.size() - logBase) < 5; c++) @(negedge clock);
      checkOutput("abort.reachedBeat5", 64'(logQ.size() - logBase), 64'd5);
      checkOutput("abort.stbBefore", 64'({cyc, stb, we}), 64'b111);
      wbResetn = 1'b0;
      #1;
      checkOutput("abort.busLow", 64'({cyc, stb, busy}), 64'd0);
      @(negedge clock);
      wbResetn = 1'b1;
      repeat (4) @(negedge clock);
      checkOutput("abort.staysIdle", 64'({cyc, busy, done}), 64'd0);
      applyStimulus(26'h100, 16'd2, 32'hA5A5_0000, 3, 1'b0, 26'h0, 1'b0);
      checkRun("rerun", 26'h100, 16'd2, 32'hA5A5_0000, 3, 1'b1, 16'd0, 26'h0);

`ifdef WB_PATTERN_LFSR_EN
      $display("[TB] LFSR run, seed 1, start held high");
      applyStimulus(26'h0, 16'd2, 32'h1, 0, 1'b0, 26'h0, 1'b1);
      checkOutput("lfsr.firstData", 64'(logQ[logBase][31:0]), 64'h1);
      checkRun("lfsr", 26'h0, 16'd2, 32'h1, 0, 1'b1, 16'd0, 26'h0);
`endif

      repeat (2) @(negedge clock);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
